// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects raw pushbuttons into a clean level and one-cycle
// press/release strobes. Define AUTO_REPEAT_EN to add hold-to-repeat press strobes.
module button_conditioner #(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 150
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] level,
    output logic [NUM_BTN-1:0] press,
    // "release" is a reserved word, hence the suffix
    output logic [NUM_BTN-1:0] release_pulse
);

    localparam int unsigned DB_CNT   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned RPT_DLY  = CLK_HZ / 1000 * REPEAT_DELAY_MS;
    localparam int unsigned RPT_RATE = CLK_HZ / 1000 * REPEAT_RATE_MS;
    localparam int unsigned MAX_A    = (DB_CNT > RPT_DLY) ? DB_CNT : RPT_DLY;
    localparam int unsigned MAX_CNT  = (MAX_A > RPT_RATE) ? MAX_A : RPT_RATE;
    localparam int unsigned CW       = $clog2(MAX_CNT + 1);

    if (DB_CNT < 1 || RPT_DLY < 1 || RPT_RATE < 1) begin : g_bad_cfg
        $error("button_conditioner: derived debounce/repeat count below 1");
    end

    typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StReleaseWait} state_e;

    logic [NUM_BTN-1:0] sync1_q, sync2_q, btn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= {NUM_BTN{ACTIVE_LOW}};
            sync2_q <= {NUM_BTN{ACTIVE_LOW}};
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign btn = sync2_q ^ {NUM_BTN{ACTIVE_LOW}};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        state_e        state_q;
        logic [CW-1:0] cnt_q;
        logic          level_q, press_q, rel_q;
`ifdef AUTO_REPEAT_EN
        logic [CW-1:0] rpt_q;
        logic          armed_q;   // first repeat already issued; later ones use RPT_RATE
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
                rpt_q   <= '0;
                armed_q <= 1'b0;
`endif
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                unique case (state_q)
                    StIdle: begin
                        if (btn[i]) begin
                            state_q <= StPressWait;
                            cnt_q   <= '0;
                        end
                    end
                    StPressWait: begin
                        if (!btn[i]) begin
                            state_q <= StIdle;
                        end else if (cnt_q == CW'(DB_CNT - 1)) begin
                            state_q <= StPressed;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
`ifdef AUTO_REPEAT_EN
                            rpt_q   <= '0;
                            armed_q <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    StPressed: begin
                        if (!btn[i]) begin
                            state_q <= StReleaseWait;
                            cnt_q   <= '0;
                        end
`ifdef AUTO_REPEAT_EN
                        else if (rpt_q == (armed_q ? CW'(RPT_RATE - 1) : CW'(RPT_DLY - 1))) begin
                            press_q <= 1'b1;
                            rpt_q   <= '0;
                            armed_q <= 1'b1;
                        end else begin
                            rpt_q <= rpt_q + CW'(1);
                        end
`endif
                    end
                    StReleaseWait: begin
                        // Repeat counter is frozen here so a bounce back resumes the cadence
                        if (btn[i]) begin
                            state_q <= StPressed;
                        end else if (cnt_q == CW'(DB_CNT - 1)) begin
                            state_q <= StIdle;
                            level_q <= 1'b0;
                            rel_q   <= 1'b1;
`ifdef AUTO_REPEAT_EN
                            rpt_q   <= '0;
                            armed_q <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end

        assign level[i]         = level_q;
        assign press[i]         = press_q;
        assign release_pulse[i] = rel_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized bench for button_conditioner against a run-length debounce model.
module tb_button_conditioner;

    localparam int DB       = 4;
    localparam int RPT_DLY  = 10;
    localparam int RPT_RATE = 3;
`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] level, press, rel;

    int checks = 0;
    int errors = 0;

    // Model: two-sample input delay, then a level flips once the input has
    // disagreed with it for DB+1 consecutive edges.
    logic [3:0] s1, s2, m_level, exp_press, exp_rel;
    int         run  [4];
    int         hold [4];

    logic [3:0] r;
    int         first, cnt, last;
    int         strobes[$];

    button_conditioner #(
        .NUM_BTN        (4),
        .CLK_HZ         (1000),
        .DEBOUNCE_MS    (4),
        .ACTIVE_LOW     (1'b1),
        .REPEAT_DELAY_MS(10),
        .REPEAT_RATE_MS (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .level        (level),
        .press        (press),
        .release_pulse(rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expected);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expected);
        end
    endtask

    function automatic bit repeat_due(input int h);
        return AUTO && (h == RPT_DLY || (h > RPT_DLY && (h - RPT_DLY) % RPT_RATE == 0));
    endfunction

    task automatic model_reset();
        s1 = '0;
        s2 = '0;
        m_level = '0;
        for (int i = 0; i < 4; i++) begin
            run[i]  = 0;
            hold[i] = 0;
        end
    endtask

    task automatic step(input logic [3:0] raw);
        logic [3:0] norm;
        logic       seen;
        btn_raw = raw;
        @(posedge clk);
        norm      = ~raw;
        exp_press = '0;
        exp_rel   = '0;
        for (int i = 0; i < 4; i++) begin
            seen  = s2[i];
            s2[i] = s1[i];
            s1[i] = norm[i];
            if (seen != m_level[i]) begin
                run[i]++;
                if (run[i] == DB + 1) begin
                    m_level[i] = seen;
                    run[i]     = 0;
                    hold[i]    = 0;
                    if (seen) exp_press[i] = 1'b1;
                    else      exp_rel[i]   = 1'b1;
                end
            end else begin
                if (m_level[i] && run[i] == 0) begin
                    hold[i]++;
                    if (repeat_due(hold[i])) exp_press[i] = 1'b1;
                end
                run[i] = 0;
            end
        end
        #1;
        check("level", level, m_level);
        check("press", press, exp_press);
        check("release", rel, exp_rel);
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_level", level, 4'b0000);
        check("rst_press", press, 4'b0000);
        check("rst_release", rel, 4'b0000);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        btn_raw = 4'hF;
        model_reset();
        #1;
        check("por_level", level, 4'b0000);
        check("por_press", press, 4'b0000);
        check("por_release", rel, 4'b0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) step(4'hF);

        // Clean press on channel 0
        first = 0;
        for (int e = 1; e <= 12; e++) begin
            step(4'hE);
            if (press[0] && first == 0) first = e;
        end
        check_int("press0_edge", first, 7);
        repeat (10) step(4'hF);

        // Bounce on channel 1
        repeat (3) step(4'hD);
        step(4'hF);
        first = 0;
        cnt   = 0;
        for (int e = 1; e <= 12; e++) begin
            step(4'hD);
            if (press[1]) begin
                cnt++;
                if (first == 0) first = e;
            end
        end
        check_int("bounce1_count", cnt, 1);
        check_int("bounce1_edge", first, 7);
        repeat (10) step(4'hF);

        // Clean release on channel 2, then a release interrupted by a 2-cycle glitch
        repeat (10) step(4'hB);
        first = 0;
        for (int e = 1; e <= 12; e++) begin
            step(4'hF);
            if (rel[2] && first == 0) first = e;
        end
        check_int("release2_edge", first, 7);
        repeat (10) step(4'hB);
        repeat (2) step(4'hF);
        cnt = 0;
        for (int e = 1; e <= 10; e++) begin
            step(4'hB);
            if (rel[2]) cnt++;
        end
        check_int("glitch2_releases", cnt, 0);
        check("glitch2_level", {3'b000, level[2]}, 4'b0001);
        repeat (10) step(4'hF);

        // Reset during press debounce, then a fresh press with the button still held
        repeat (4) step(4'hE);
        async_reset();
        first = 0;
        for (int e = 1; e <= 10; e++) begin
            step(4'hE);
            if (press[0] && first == 0) first = e;
        end
        check_int("fresh_press_edge", first, 7);
        async_reset();
        repeat (10) step(4'hF);

        // All four channels pressed together
        first = 0;
        for (int e = 1; e <= 8; e++) begin
            step(4'h0);
            if (press != 4'b0000 && first == 0) begin
                first = e;
                check("simul_press", press, 4'b1111);
            end
        end
        check_int("simul_edge", first, 7);
        repeat (10) step(4'hF);

        // Long hold on channel 0: auto-repeat cadence (single strobe when disabled)
        strobes.delete();
        for (int e = 1; e <= 30; e++) begin
            step(4'hE);
            if (press[0]) strobes.push_back(e);
        end
        check_int("hold_strobes", strobes.size(), AUTO ? 6 : 1);
        last = 0;
        for (int k = 0; k < strobes.size(); k++) begin
            last = (k == 0) ? 7 : (k == 1) ? 17 : last + RPT_RATE;
            check_int("hold_strobe_edge", strobes[k], last);
        end
        cnt = 0;
        for (int e = 1; e <= 20; e++) begin
            step(4'hF);
            if (press[0]) cnt++;
        end
        check_int("after_release_press", cnt, 0);

        // Randomized toggling on all channels
        r = 4'hF;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(5) == 0) r[b] = ~r[b];
            end
            step(r);
        end
        repeat (12) step(4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage of the digital-clock / countdown-timer datapath.
- Takes raw, bouncing board pushbuttons (e.g. set-second, set-minute, start, clear).
- Synchronises and debounces each one, then produces a clean level plus single-cycle press and release strobes.
- Timer and clock modes consume the strobes directly, so they need no debounce logic of their own.

Parameters:
- NUM_BTN, 4: number of independent button channels.
- CLK_HZ, 50000000: clk frequency in Hz.
- DEBOUNCE_MS, 20: stable time required before a level change is accepted.
- ACTIVE_LOW, 1: 1 = raw button reads 0 when pressed (board KEYs); 0 = reads 1 when pressed.
- REPEAT_DELAY_MS, 500: hold time before the first auto-repeat strobe (AUTO_REPEAT_EN only).
- REPEAT_RATE_MS, 150: interval between subsequent auto-repeat strobes (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- btn_raw  input  NUM_BTN  raw pushbutton pins, asynchronous to clk.
- level  output  NUM_BTN  debounced pressed state, 1 = pressed.
- press  output  NUM_BTN  one-cycle strobe on accepted press (and on auto-repeat when enabled).
- release  output  NUM_BTN  one-cycle strobe on accepted release.

Behaviour:
- Derived constants:
  - DB_CNT = CLK_HZ/1000*DEBOUNCE_MS (integer).
  - RPT_DLY and RPT_RATE are derived the same way.
  - Elaboration fails if any of these is < 1.
  - Counter width = clog2(max constant + 1).
- Reset (reset = 0, asynchronous):
  - All FSMs go to IDLE; counters clear.
  - Synchroniser flops load the "not pressed" value.
  - level, press and release all go to 0.
  - Deassertion takes effect on the next rising clk edge.
- Per channel: two-flop synchroniser, then polarity normalisation (btn = sync XOR ACTIVE_LOW, so 1 = pressed).
- Per-channel FSM, one debounce counter each; all outputs registered:
  - IDLE (level 0): btn=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT (level 0): btn=0 -> IDLE (bounce rejected, no strobe). Else if cnt==DB_CNT-1 -> PRESSED, level<=1, press<=1 for one cycle. Else cnt++.
  - PRESSED (level 1): btn=0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT (level 1): btn=1 -> PRESSED (bounce rejected, no strobe). Else if cnt==DB_CNT-1 -> IDLE, level<=0, release<=1 for one cycle. Else cnt++.
- Latency:
  - Count the first rising edge that samples a new stable raw value as edge 1.
  - level changes and press/release rise on edge DB_CNT+3.
  - Strobes last exactly one clk cycle.
- Glitches: any raw glitch shorter than DB_CNT cycles at the synchroniser output produces no level change and no strobe.
- Channel independence: channels never interact; simultaneous presses on several channels yield simultaneous strobes.
- Strobe exclusivity: press and release are never high together on the same channel.
- Reset mid-debounce: state and counter are discarded; no strobe is emitted.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - A per-channel repeat counter runs while in PRESSED.
  - It clears on entry to PRESSED and on leaving PRESSED.
  - After RPT_DLY cycles in PRESSED: extra one-cycle press strobe.
  - Then a further strobe every RPT_RATE cycles while held.
  - RELEASE_WAIT freezes the repeat counter; bouncing back to PRESSED resumes it without clearing.
  - level is unaffected by repeats.
- Undefined:
  - Repeat logic and parameters are unused.
  - Exactly one press strobe per accepted press.

Test Plan (CLK_HZ=1000, DEBOUNCE_MS=4 -> DB_CNT=4, ACTIVE_LOW=1, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=3):
- Clean press: btn_raw[0] 1->0 held -> press[0]=1 for one cycle and level[0]=1 at edge 7; no other channel strobes.
- Bounce rejection: btn_raw[1] low 3 cycles, high 1, low steady -> exactly one press[1] strobe, 7 edges after the final falling transition; level stays 0 before it.
- Clean release: after level[2]=1, btn_raw[2] 0->1 held -> release[2] one cycle at edge 7, level[2]=0; glitch low for 2 cycles mid-release -> no release, level stays 1.
- Async reset: reset=0 mid PRESS_WAIT and mid PRESSED -> level/press/release 0 immediately without a clock edge; after release with buttons still held -> fresh press after 7 edges.
- Simultaneous: all 4 buttons pressed on the same cycle -> press=4'b1111 on one cycle, then 0.
- AUTO_REPEAT_EN: hold btn_raw[0] 30 cycles -> strobes at edge 7, then 10 cycles later, then every 3 cycles; none after release; undefined build -> single strobe.
